aes_req_arbiter: RTL and testbench

Shares the single AES-128 decryption core among NUM_REQ requesters. Accepts one {cyphertext, key} job at a time using round-robin arbitration, launches the core, and watches for completion with a cycle-count watchdog. Returns the plaintext with the winning requester's ID. Sits between the client ports and the core wrapper; the core's own round controller is unchanged.

---
 rtl/aes_req_arbiter_pkg.sv | 17 +
 rtl/aes_req_arbiter_rr_arbiter.sv | 26 ++
 rtl/aes_req_arbiter.sv | 144 ++++++++++++++
 tb/tb_aes_req_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_req_arbiter_pkg.sv
// Shared definitions for the AES request arbiter: data widths, FSM states and response codes.
package aes_req_arbiter_pkg;

  localparam int unsigned TEXT_WIDTH = 128;
  localparam int unsigned KEY_WIDTH  = 128;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StWait  = 3'd2,
    StResp  = 3'd3,
    StFlush = 3'd4
  } state_e;

  localparam logic RSP_ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/aes_req_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr_i.
module aes_req_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  always_comb begin
    logic            found;
    logic [IdxW-1:0] idx;
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IdxW'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin front end for the shared AES-128 decryption core, with a completion watchdog.
module aes_req_arbiter
  import aes_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 63,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*TEXT_WIDTH-1:0] req_text_i,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]  req_key_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [IdxW-1:0]               rsp_id_o,
  output logic [TEXT_WIDTH-1:0]         rsp_text_o,
  output logic                          rsp_error_o,
  output logic                          core_start_o,
  output logic                          core_flush_o,
  output logic [TEXT_WIDTH-1:0]         core_text_o,
  output logic [KEY_WIDTH-1:0]          core_key_o,
  input  logic                          core_finish_i,
  input  logic [TEXT_WIDTH-1:0]         core_text_i,
  output logic                          busy_o
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       id_q;
  logic [WdW-1:0]        wd_q;
  logic [NUM_REQ-1:0]    grant;
  logic [IdxW-1:0]       grant_idx;
  logic [TEXT_WIDTH-1:0] sel_text;
  logic [KEY_WIDTH-1:0]  sel_key;
  logic                  accept;

  logic [TEXT_WIDTH-1:0] core_text_q, rsp_text_q;
  logic [KEY_WIDTH-1:0]  core_key_q;
  logic                  core_start_q, core_flush_q, rsp_valid_q, rsp_error_q, busy_q;

  aes_req_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  assign accept      = (state_q == StIdle) && (|req_valid_i);
  assign req_ready_o = (state_q == StIdle) ? grant : '0;

  always_comb begin
    grant_idx = '0;
    sel_text  = '0;
    sel_key   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = IdxW'(i);
        sel_text  = req_text_i[i*TEXT_WIDTH +: TEXT_WIDTH];
        sel_key   = req_key_i[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle:  if (|req_valid_i) state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        // Finish has priority over an expiring watchdog.
        if (core_finish_i)      state_d = StResp;
        else if (wd_q == WdMax) state_d = StFlush;
      end
      StFlush: state_d = StResp;
      StResp: begin
        if (rsp_ready_i) begin
          state_d  = StIdle;
          rr_ptr_d = (id_q == IdxW'(NUM_REQ - 1)) ? '0 : id_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      wd_q         <= '0;
      core_text_q  <= '0;
      core_key_q   <= '0;
      rsp_text_q   <= '0;
      rsp_error_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      core_flush_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= (state_d == StResp);
      core_start_q <= (state_d == StStart);
      core_flush_q <= (state_d == StFlush);
      busy_q       <= (state_d != StIdle);
      if (accept) begin
        id_q        <= grant_idx;
        core_text_q <= sel_text;
        core_key_q  <= sel_key;
      end
      // Counting from START makes the WAIT budget exactly TIMEOUT cycles.
      if (state_q == StIdle) begin
        wd_q <= '0;
      end else if ((state_q == StStart) || ((state_q == StWait) && (state_d == StWait))) begin
        wd_q <= wd_q + WdW'(1);
      end
      if ((state_q == StWait) && core_finish_i) begin
        rsp_text_q  <= core_text_i;
        rsp_error_q <= 1'b0;
      end else if ((state_q == StWait) && (state_d == StFlush)) begin
        rsp_text_q  <= '0;
        rsp_error_q <= RSP_ERR_TIMEOUT;
      end
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = id_q;
  assign rsp_text_o   = rsp_text_q;
  assign rsp_error_o  = rsp_error_q;
  assign core_start_o = core_start_q;
  assign core_flush_o = core_flush_q;
  assign core_text_o  = core_text_q;
  assign core_key_o   = core_key_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomized bench for aes_req_arbiter: a job-level model predicts winner, latency and payload.
module tb_aes_req_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TO  = 63;
  localparam int unsigned IW  = $clog2(N);
  localparam int          INF = 1000000;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic [N-1:0]     req_valid_i = '0;
  logic [N-1:0]     req_ready_o;
  logic [N*128-1:0] req_text_i = '0;
  logic [N*128-1:0] req_key_i = '0;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b0;
  logic [IW-1:0]    rsp_id_o;
  logic [127:0]     rsp_text_o;
  logic             rsp_error_o;
  logic             core_start_o;
  logic             core_flush_o;
  logic [127:0]     core_text_o;
  logic [127:0]     core_key_o;
  logic             core_finish_i = 1'b0;
  logic [127:0]     core_text_i = '0;
  logic             busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int ptr_m    = 0;

  aes_req_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_text_i    (req_text_i),
    .req_key_i     (req_key_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_id_o      (rsp_id_o),
    .rsp_text_o    (rsp_text_o),
    .rsp_error_o   (rsp_error_o),
    .core_start_o  (core_start_o),
    .core_flush_o  (core_flush_o),
    .core_text_o   (core_text_o),
    .core_key_o    (core_key_o),
    .core_finish_i (core_finish_i),
    .core_text_i   (core_text_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // First requesting index at or after p, wrapping.
  function automatic int model_grant(input logic [N-1:0] m, input int p);
    logic [N-1:0] sh;
    for (int i = 0; i < int'(N); i++) begin
      sh = m >> ((p + i) % N);
      if (sh[0]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic check_idle_outputs(input string nm);
    check_val({nm, "_ctl"}, {req_ready_o, rsp_valid_o, rsp_id_o, rsp_error_o, core_start_o,
                             core_flush_o, busy_o}, '0);
    check_val({nm, "_rsp_text"}, rsp_text_o, '0);
    check_val({nm, "_core_tk"}, core_text_o | core_key_o, '0);
  endtask

  // finish_at: cycle after accept where core_finish_i goes high (-1 = never).
  // hold: cycles rsp_ready_i stays low once the response is visible.
  task automatic do_job(input logic [N-1:0] vmask, input int finish_at, input int hold,
                        input string nm);
    logic [127:0] txt[N];
    logic [127:0] key[N];
    logic [127:0] ptxt, exp_text, s_text;
    logic [IW-1:0] s_id;
    logic s_err;
    int win, eff, exp_rsp, first_rsp, first_start, n_start, n_flush, flush_t;
    int extra_ready, unstable;
    bit timed_out, done;
    win = model_grant(vmask, ptr_m);
    for (int k = 0; k < int'(N); k++) begin
      txt[k] = rand128();
      key[k] = rand128();
    end
    ptxt      = rand128();
    eff       = (finish_at < 0) ? INF : ((finish_at < 2) ? 2 : finish_at);
    timed_out = (eff > int'(TO) + 1);
    exp_rsp   = timed_out ? int'(TO) + 3 : eff + 1;
    exp_text  = timed_out ? '0 : ptxt;
    first_rsp = -1; first_start = -1; flush_t = -1;
    n_start = 0; n_flush = 0; extra_ready = 0; unstable = 0; done = 0;
    s_text = '0; s_id = '0; s_err = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(posedge clk_i); #1;
      req_valid_i = (t == 0) ? vmask : (vmask & ~(N'(1) << win));
      for (int k = 0; k < int'(N); k++) begin
        req_text_i[k*128 +: 128] = txt[k];
        req_key_i[k*128 +: 128]  = key[k];
      end
      core_text_i   = ptxt;
      core_finish_i = (finish_at >= 0) && (t >= finish_at);
      rsp_ready_i   = (hold == 0) || ((first_rsp >= 0) && (t >= first_rsp + hold));
      @(negedge clk_i);
      if (t == 0) begin
        check_val({nm, "_ready"}, req_ready_o, N'(1) << win);
        check_val({nm, "_busy0"}, busy_o, 0);
      end else if (req_ready_o != '0) begin
        extra_ready++;
      end
      if (t == 1) begin
        check_val({nm, "_busy1"}, busy_o, 1);
        check_val({nm, "_core_text"}, core_text_o, txt[win]);
        check_val({nm, "_core_key"}, core_key_o, key[win]);
      end
      if (core_start_o) begin
        n_start++;
        if (first_start < 0) first_start = t;
      end
      if (core_flush_o) begin
        n_flush++;
        flush_t = t;
      end
      if (rsp_valid_o && first_rsp < 0) begin
        first_rsp = t;
        check_val({nm, "_rsp_cycle"}, t, exp_rsp);
        check_val({nm, "_rsp_id"}, rsp_id_o, win);
        check_val({nm, "_rsp_text"}, rsp_text_o, exp_text);
        check_val({nm, "_rsp_err"}, rsp_error_o, timed_out);
        s_text = rsp_text_o; s_id = rsp_id_o; s_err = rsp_error_o;
      end else if (first_rsp >= 0) begin
        if (!rsp_valid_o || rsp_text_o !== s_text || rsp_id_o !== s_id || rsp_error_o !== s_err)
          unstable++;
      end
      if (rsp_valid_o && rsp_ready_i) done = 1;
    end
    if (!done) check_val({nm, "_handshake_bound"}, 0, 1);
    check_val({nm, "_start_cycle"}, first_start, 1);
    check_val({nm, "_start_count"}, n_start, 1);
    check_val({nm, "_flush_count"}, n_flush, timed_out ? 1 : 0);
    if (timed_out) check_val({nm, "_flush_cycle"}, flush_t, TO + 2);
    check_val({nm, "_extra_ready"}, extra_ready, 0);
    check_val({nm, "_rsp_stable"}, unstable, 0);
    ptr_m = (win + 1) % N;
  endtask

  initial begin
    int fin, msk;
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_idle_outputs("reset");
    @(posedge clk_i); #1 rst_ni = 1'b1;
    ptr_m = 0;

    for (int j = 0; j < 5; j++) do_job(4'b1111, 1 + $urandom_range(1, 12), 0, "rr");
    do_job(4'b0100, 13, 0, "single");
    do_job(4'b1111, $urandom_range(2, 10), 20, "backpressure");
    do_job(4'b1011, -1, 0, "timeout");
    do_job(4'b1111, TO + 1, 0, "finish_at_limit");
    do_job(4'b0110, TO + 2, 2, "finish_after_limit");

    for (int j = 0; j < 25; j++) begin
      msk = $urandom_range(1, (1 << N) - 1);
      case ($urandom_range(0, 9))
        0:       fin = -1;
        1:       fin = TO + 1;
        default: fin = $urandom_range(0, 20);
      endcase
      do_job(N'(msk), fin, $urandom_range(0, 3), "rand");
    end

    // Abort a job mid-WAIT with reset, then leave a stale finish asserted.
    @(posedge clk_i); #1;
    req_valid_i = 4'b1000; core_finish_i = 1'b0; rsp_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1 req_valid_i = '0;
    core_finish_i = 1'b1;
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("reset_wait");
    @(posedge clk_i); #1 rst_ni = 1'b1;
    ptr_m = 0;
    do_job(4'b1111, 0, 0, "after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
